// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline definitions: instruction constants, fetch FSM states, fetch error codes.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package riscv_pkg;

  // addi x0, x0, 0 -- the canonical bubble held in an empty IF/ID register.
  localparam logic [31:0] NOP_INST          = 32'h0000_0013;
  // ecall -- default instruction word that stops fetch.
  localparam logic [31:0] HALT_INST_DEFAULT = 32'h0000_0073;

  typedef enum logic [1:0] {
    FS_IDLE = 2'd0,
    FS_RUN  = 2'd1,
    FS_HALT = 2'd2,
    FS_ERR  = 2'd3
  } fetch_state_e;

  localparam logic [1:0] FERR_NONE     = 2'b00;
  localparam logic [1:0] FERR_MISALIGN = 2'b01;
  localparam logic [1:0] FERR_RANGE    = 2'b10;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: load captures a fetched instruction, clear drops valid, otherwise hold.
// Latency: 1 cycle from load inputs to outputs.
// Backpressure: hold (load=0, clear=0) freezes contents for a stalled decode stage.
//
// Ports:
//   clk, rst               clock and synchronous active-high reset
//   load                   capture load_pc / load_pc_plus4 / load_inst with valid=1
//   clear                  squash: valid<=0, payload left as is
//   load_pc, load_pc_plus4, load_inst   incoming fetch bundle
//   valid, pc, pc_plus4, inst           registered bundle consumed by decode
module if_id_reg
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        clear,
  input  logic [31:0] load_pc,
  input  logic [31:0] load_pc_plus4,
  input  logic [31:0] load_inst,
  output logic        valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] inst
);

  always_ff @(posedge clk) begin
    if (rst) begin
      valid    <= 1'b0;
      pc       <= 32'h0000_0000;
      pc_plus4 <= 32'h0000_0004;
      inst     <= NOP_INST;
    end else if (load) begin
      valid    <= 1'b1;
      pc       <= load_pc;
      pc_plus4 <= load_pc_plus4;
      inst     <= load_inst;
    end else if (clear) begin
      valid    <= 1'b0;
    end
  end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch: PC register, next-PC mux, fetch FSM (IDLE/RUN/HALT/ERR), fetch counter, IF/ID.
// Latency: PC presented in cycle N is valid in IF/ID after edge N+1; a redirect costs one bubble.
// Backpressure: stall holds PC and IF/ID; a redirect overrides stall; flush refetches the same PC.
//
// Ports:
//   clk, rst                     clock and synchronous active-high reset
//   start                        level; leaves IDLE once the ROM is loaded
//   stall, flush                 hazard-unit controls
//   redirect_valid, redirect_pc  taken branch / jump from EX
//   rom_read_enable, rom_addr    ROM request (rom_addr is the PC)
//   rom_inst                     same-cycle combinational ROM data
//   if_id_*                      IF/ID pipeline register contents
//   halted, fetch_err            registered status (01 misaligned redirect, 10 PC out of range)
//   fetch_count                  number of valid IF/ID captures, wraps silently
module inst_fetch
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC      = 32'h0000_0000,
  parameter int unsigned INST_MEM_SIZE = 16,
  parameter logic [31:0] HALT_INST     = HALT_INST_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        rom_read_enable,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_inst,
  output logic        if_id_valid,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_pc_plus4,
  output logic [31:0] if_id_inst,
  output logic        halted,
  output logic [1:0]  fetch_err,
  output logic [31:0] fetch_count
);

  localparam logic [31:0] PC_LIMIT = 32'(4 * INST_MEM_SIZE);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [1:0]   err_q, err_d;
  logic [31:0]  cnt_q;
  logic [31:0]  pc_plus4;
  logic         redirect_aligned;
  logic         ifid_load;
  logic         ifid_clear;
  logic         cnt_inc;

  // Wraps modulo 2^32; a wrapped PC is caught by the range check before any capture.
  assign pc_plus4         = pc_q + 32'd4;
  assign redirect_aligned = (redirect_pc[1:0] == 2'b00);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    err_d      = err_q;
    ifid_load  = 1'b0;
    ifid_clear = 1'b0;
    cnt_inc    = 1'b0;

    unique case (state_q)
      FS_IDLE: begin
        if (start) state_d = FS_RUN;
      end

      FS_RUN: begin
        if (redirect_valid) begin
          // Redirect beats stall and flush: the instruction in fetch is on a dead path.
          ifid_clear = 1'b1;
          if (!redirect_aligned) begin
            state_d = FS_ERR;
            err_d   = FERR_MISALIGN;
          end else begin
            pc_d = redirect_pc;
          end
        end else if (flush) begin
          ifid_clear = 1'b1;
        end else if (stall) begin
          // Hold PC and IF/ID.
        end else if (pc_q >= PC_LIMIT) begin
          state_d    = FS_ERR;
          err_d      = FERR_RANGE;
          ifid_clear = 1'b1;
        end else begin
          ifid_load = 1'b1;
          pc_d      = pc_plus4;
          cnt_inc   = 1'b1;
          // The halt word itself is captured so decode still sees it.
          if (rom_inst == HALT_INST) state_d = FS_HALT;
        end
      end

      FS_HALT: begin
        if (redirect_valid) begin
          // The halt was on a squashed path; resume at the redirect target.
          ifid_clear = 1'b1;
          if (!redirect_aligned) begin
            state_d = FS_ERR;
            err_d   = FERR_MISALIGN;
          end else begin
            pc_d    = redirect_pc;
            state_d = FS_RUN;
          end
        end else if (!stall) begin
          ifid_clear = 1'b1;
        end
      end

      FS_ERR: begin
        ifid_clear = 1'b1;
      end

      default: begin
        state_d = FS_ERR;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FS_IDLE;
      pc_q    <= RESET_PC;
      err_q   <= FERR_NONE;
      cnt_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      err_q   <= err_d;
      if (cnt_inc) cnt_q <= cnt_q + 32'd1;
    end
  end

  assign rom_read_enable = (state_q == FS_RUN);
  assign rom_addr        = pc_q;
  assign halted          = (state_q == FS_HALT);
  assign fetch_err       = err_q;
  assign fetch_count     = cnt_q;

  if_id_reg u_if_id_reg (
    .clk           (clk),
    .rst           (rst),
    .load          (ifid_load),
    .clear         (ifid_clear),
    .load_pc       (pc_q),
    .load_pc_plus4 (pc_plus4),
    .load_inst     (rom_inst),
    .valid         (if_id_valid),
    .pc            (if_id_pc),
    .pc_plus4      (if_id_pc_plus4),
    .inst          (if_id_inst)
  );

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: vector table, directed corner sequences, random run against a reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_inst_fetch;

  localparam logic N = 1'b0;
  localparam logic Y = 1'b1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        rom_read_enable;
  logic [31:0] rom_addr;
  logic [31:0] rom_inst;
  logic        if_id_valid;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_pc_plus4;
  logic [31:0] if_id_inst;
  logic        halted;
  logic [1:0]  fetch_err;
  logic [31:0] fetch_count;

  logic [31:0] rom [16];

  always #5 clk = ~clk;

  assign rom_inst = (rom_addr < 32'd64) ? rom[rom_addr[5:2]] : 32'h0000_0000;

  inst_fetch dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .stall           (stall),
    .flush           (flush),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .rom_read_enable (rom_read_enable),
    .rom_addr        (rom_addr),
    .rom_inst        (rom_inst),
    .if_id_valid     (if_id_valid),
    .if_id_pc        (if_id_pc),
    .if_id_pc_plus4  (if_id_pc_plus4),
    .if_id_inst      (if_id_inst),
    .halted          (halted),
    .fetch_err       (fetch_err),
    .fetch_count     (fetch_count)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: mode 0 idle, 1 running, 2 halted, 3 error.
  int          m_mode = 0;
  logic [31:0] m_pc   = 32'h0;
  logic        m_v    = 1'b0;
  logic [31:0] m_ipc  = 32'h0;
  logic [31:0] m_inst = 32'h13;
  logic [1:0]  m_err  = 2'b00;
  logic [31:0] m_cnt  = 32'h0;

  task automatic model_edge(input logic r, input logic s, input logic st, input logic fl,
                            input logic rv, input logic [31:0] rp);
    logic [31:0] w;
    if (r) begin
      m_mode = 0; m_pc = 32'h0; m_v = 1'b0; m_ipc = 32'h0; m_inst = 32'h13;
      m_err = 2'b00; m_cnt = 32'h0;
      return;
    end
    case (m_mode)
      0: if (s) m_mode = 1;
      1: begin
        if (rv) begin
          m_v = 1'b0;
          if (rp % 4 != 0) begin m_mode = 3; m_err = 2'b01; end
          else m_pc = rp;
        end else if (fl) begin
          m_v = 1'b0;
        end else if (st) begin
        end else if (m_pc >= 32'd64) begin
          m_mode = 3; m_err = 2'b10; m_v = 1'b0;
        end else begin
          w = rom[m_pc / 4];
          m_v = 1'b1; m_ipc = m_pc; m_inst = w;
          m_pc = m_pc + 32'd4;
          m_cnt = m_cnt + 32'd1;
          if (w == 32'h0000_0073) m_mode = 2;
        end
      end
      2: begin
        if (rv) begin
          m_v = 1'b0;
          if (rp % 4 != 0) begin m_mode = 3; m_err = 2'b01; end
          else begin m_pc = rp; m_mode = 1; end
        end else if (!st) begin
          m_v = 1'b0;
        end
      end
      default: begin end
    endcase
  endtask

  task automatic check_model();
    if (m_mode != 2) chk("rd_en", {31'd0, rom_read_enable}, {31'd0, m_mode == 1});
    chk("rom_addr", rom_addr, m_pc);
    chk("valid", {31'd0, if_id_valid}, {31'd0, m_v});
    if (m_v) begin
      chk("if_id_pc", if_id_pc, m_ipc);
      chk("if_id_pc4", if_id_pc_plus4, m_ipc + 32'd4);
      chk("if_id_inst", if_id_inst, m_inst);
    end
    chk("halted", {31'd0, halted}, {31'd0, m_mode == 2});
    chk("fetch_err", {30'd0, fetch_err}, {30'd0, m_err});
    chk("fetch_count", fetch_count, m_cnt);
  endtask

  task automatic step(input logic r, input logic s, input logic st, input logic fl,
                      input logic rv, input logic [31:0] rp);
    rst = r; start = s; stall = st; flush = fl; redirect_valid = rv; redirect_pc = rp;
    @(posedge clk);
    model_edge(r, s, st, fl, rv, rp);
    #1;
    check_model();
  endtask

  task automatic reset_run();
    step(Y, N, N, N, N, 32'h0);
    step(N, Y, N, N, N, 32'h0);
  endtask

  task automatic run1();
    step(N, Y, N, N, N, 32'h0);
  endtask

  typedef struct {
    logic        r, s, st, fl, rv;
    logic [31:0] rp;
    logic        e_v;
    logic [31:0] e_pc;
    logic [31:0] e_addr;
    logic        e_h;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t tbl[9];

  initial begin
    for (int i = 0; i < 16; i++) rom[i] = 32'h1000_0000 + 32'(i);
    rom[0] = 32'h0010_0093;
    rom[1] = 32'h0020_0113;
    rom[2] = 32'h0030_0193;
    rom[3] = 32'h0040_0213;
    rom[4] = 32'h0000_0073;

    // Straight-line fetch to the halt word, then HALT behaviour.
    tbl[0] = '{Y, N, N, N, N, 32'h0, N, 32'h0,  32'h0,  N, 32'd0};
    tbl[1] = '{N, Y, N, N, N, 32'h0, N, 32'h0,  32'h0,  N, 32'd0};
    tbl[2] = '{N, Y, N, N, N, 32'h0, Y, 32'h0,  32'h4,  N, 32'd1};
    tbl[3] = '{N, Y, N, N, N, 32'h0, Y, 32'h4,  32'h8,  N, 32'd2};
    tbl[4] = '{N, Y, N, N, N, 32'h0, Y, 32'h8,  32'hC,  N, 32'd3};
    tbl[5] = '{N, Y, N, N, N, 32'h0, Y, 32'hC,  32'h10, N, 32'd4};
    tbl[6] = '{N, Y, N, N, N, 32'h0, Y, 32'h10, 32'h14, Y, 32'd5};
    tbl[7] = '{N, Y, N, N, N, 32'h0, N, 32'h0,  32'h14, Y, 32'd5};
    tbl[8] = '{N, Y, N, Y, N, 32'h0, N, 32'h0,  32'h14, Y, 32'd5};

    for (int i = 0; i < 9; i++) begin
      step(tbl[i].r, tbl[i].s, tbl[i].st, tbl[i].fl, tbl[i].rv, tbl[i].rp);
      chk($sformatf("tbl%0d_valid", i), {31'd0, if_id_valid}, {31'd0, tbl[i].e_v});
      chk($sformatf("tbl%0d_addr", i), rom_addr, tbl[i].e_addr);
      chk($sformatf("tbl%0d_halted", i), {31'd0, halted}, {31'd0, tbl[i].e_h});
      chk($sformatf("tbl%0d_count", i), fetch_count, tbl[i].e_cnt);
      chk($sformatf("tbl%0d_err", i), {30'd0, fetch_err}, 32'd0);
      if (tbl[i].e_v) chk($sformatf("tbl%0d_pc", i), if_id_pc, tbl[i].e_pc);
    end

    // Stall for three cycles with PC=8.
    reset_run();
    run1();
    run1();
    for (int i = 0; i < 3; i++) begin
      step(N, Y, Y, N, N, 32'h0);
      chk("stall_addr", rom_addr, 32'h8);
      chk("stall_ifpc", if_id_pc, 32'h4);
      chk("stall_valid", {31'd0, if_id_valid}, 32'd1);
    end
    run1();
    chk("stall_resume_pc", if_id_pc, 32'h8);

    // Redirect in RUN: one bubble, then the target; the same with stall asserted.
    reset_run();
    run1();
    step(N, Y, N, N, Y, 32'h20);
    chk("redir_bubble", {31'd0, if_id_valid}, 32'd0);
    chk("redir_addr", rom_addr, 32'h20);
    run1();
    chk("redir_valid", {31'd0, if_id_valid}, 32'd1);
    chk("redir_pc", if_id_pc, 32'h20);
    step(N, Y, Y, N, Y, 32'h20);
    chk("redir_st_bubble", {31'd0, if_id_valid}, 32'd0);
    chk("redir_st_addr", rom_addr, 32'h20);
    run1();
    chk("redir_st_pc", if_id_pc, 32'h20);

    // Misaligned redirect: sticky error, later redirect ignored.
    step(N, Y, N, N, Y, 32'h22);
    chk("mis_err", {30'd0, fetch_err}, 32'h1);
    chk("mis_rden", {31'd0, rom_read_enable}, 32'd0);
    step(N, Y, N, Y, Y, 32'h8);
    run1();
    run1();
    chk("mis_sticky_err", {30'd0, fetch_err}, 32'h1);
    chk("mis_sticky_valid", {31'd0, if_id_valid}, 32'd0);
    chk("mis_sticky_addr", rom_addr, 32'h24);

    // Fetch off the end of the ROM.
    reset_run();
    step(N, Y, N, N, Y, 32'h3C);
    run1();
    chk("range_last_pc", if_id_pc, 32'h3C);
    chk("range_addr", rom_addr, 32'h40);
    run1();
    chk("range_err", {30'd0, fetch_err}, 32'h2);
    chk("range_valid", {31'd0, if_id_valid}, 32'd0);
    chk("range_count", fetch_count, 32'd1);

    // HALT, redirect out of it, then reset during a stall.
    reset_run();
    for (int i = 0; i < 5; i++) run1();
    chk("halt_set", {31'd0, halted}, 32'd1);
    step(N, Y, N, N, Y, 32'h8);
    chk("halt_exit", {31'd0, halted}, 32'd0);
    run1();
    chk("halt_exit_pc", if_id_pc, 32'h8);
    chk("halt_exit_valid", {31'd0, if_id_valid}, 32'd1);
    step(N, Y, Y, N, N, 32'h0);
    step(Y, Y, Y, N, N, 32'h0);
    chk("rst_rden", {31'd0, rom_read_enable}, 32'd0);
    chk("rst_addr", rom_addr, 32'h0);
    chk("rst_valid", {31'd0, if_id_valid}, 32'd0);
    chk("rst_ifpc", if_id_pc, 32'h0);
    chk("rst_ifpc4", if_id_pc_plus4, 32'h4);
    chk("rst_inst", if_id_inst, 32'h13);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_err", {30'd0, fetch_err}, 32'd0);
    chk("rst_count", fetch_count, 32'd0);

    // Random traffic against the model.
    for (int i = 0; i < 16; i++)
      rom[i] = ($urandom_range(0, 7) == 0) ? 32'h0000_0073 : ($urandom | 32'h8000_0000);
    reset_run();
    for (int i = 0; i < 3000; i++) begin
      logic        r, s, st, fl, rv;
      logic [31:0] rp;
      r  = ($urandom_range(0, 39) == 0);
      s  = ($urandom_range(0, 9) != 0);
      st = ($urandom_range(0, 3) == 0);
      fl = ($urandom_range(0, 7) == 0);
      rv = ($urandom_range(0, 9) == 0);
      case ($urandom_range(0, 15))
        0:       rp = 32'(4 * $urandom_range(0, 18)) + 32'($urandom_range(1, 3));
        1:       rp = 32'hFFFF_FFFC;
        default: rp = 32'(4 * $urandom_range(0, 18));
      endcase
      step(r, s, st, fl, rv, rp);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction-fetch stage of the single-issue RISC-V core. Holds the program counter, drives the address and read-enable of the instruction ROM (combinational read, word index = address>>2), and captures the returned word into the IF/ID pipeline register for decode. Handles stall and flush from the hazard unit, branch/jump redirects from EX, a start gate so the bench can preload the ROM, and halt/error detection.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- INST_MEM_SIZE, 16, ROM depth in 32-bit words; the legal PC range is [0, 4*INST_MEM_SIZE).
- HALT_INST, 32'h0000_0073 (ecall), instruction word that stops fetch.
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  level; leaves IDLE once the ROM is loaded.
- stall  in  1  hold PC and IF/ID.
- flush  in  1  squash IF/ID contents.
- redirect_valid  in  1  taken branch or jump from EX.
- redirect_pc  in  32  target of the redirect.
- rom_read_enable  out  1  ROM read enable.
- rom_addr  out  32  ROM address; equals the PC.
- rom_inst  in  32  ROM data, same-cycle combinational.
- if_id_valid  out  1  IF/ID holds a real instruction.
- if_id_pc  out  32  PC of the IF/ID instruction.
- if_id_pc_plus4  out  32  if_id_pc + 4.
- if_id_inst  out  32  instruction word.
- halted  out  1  state is HALT.
- fetch_err  out  2  00 none, 01 misaligned redirect, 10 PC out of range.
- fetch_count  out  32  number of valid IF/ID captures.

## Operation
- States: IDLE, RUN, HALT, ERR.
- IDLE: rom_read_enable=0; PC held; IF/ID invalid. Goes to RUN on the first cycle with start=1.
- RUN: rom_read_enable=1, rom_addr=PC. Each edge applies the first matching case, in priority order:
  1. redirect_valid: if redirect_pc[1:0]!=0, go to ERR with fetch_err=01. Otherwise PC<=redirect_pc. In both cases if_id_valid<=0.
  2. flush: if_id_valid<=0; PC held, so the same address is refetched.
  3. stall: PC and all if_id_* held.
  4. PC >= 4*INST_MEM_SIZE: go to ERR with fetch_err=10; if_id_valid<=0.
  5. Normal: capture PC, PC+4 and rom_inst into IF/ID with valid=1; PC<=PC+4; fetch_count++. If rom_inst==HALT_INST, go to HALT after the capture.
- HALT: PC held. A stall holds IF/ID; otherwise if_id_valid<=0. redirect_valid means the halt instruction was on a squashed path: apply case 1 and return to RUN. flush alone does nothing.
- ERR: sticky until rst. IF/ID invalid, rom_read_enable=0, fetch_err held. redirect, flush and start are ignored.
- Arithmetic: PC+4 is 32-bit and wraps modulo 2^32; the range check catches any wrap. fetch_count wraps silently.

## Timing
- Reset values: PC=RESET_PC, state IDLE, rom_read_enable=0, rom_addr=RESET_PC, if_id_valid=0, if_id_pc=0, if_id_pc_plus4=4, if_id_inst=32'h0000_0013 (NOP), halted=0, fetch_err=00, fetch_count=0.
- rst asserted in any state, mid-stall included, restores all reset values on the next edge.
- Latency: the PC presented in cycle N appears in IF/ID after edge N+1. Throughput is 1 instruction per cycle when stall=0.
- A redirect asserted in cycle N puts the target on rom_addr in cycle N+1. The target's instruction is valid in IF/ID after edge N+2, which is one bubble.
- redirect_valid together with stall: the redirect wins.
- start=1 arriving while the bench is still writing the ROM is the bench's responsibility; fetch issues no write-conflict checks.
- halted and fetch_err are registered, taking effect on the edge of the transition.

## Structure
- Shared package riscv_pkg holds: NOP_INST, the default HALT_INST, the fetch state enum, and the fetch_err code constants.
- Sub-module if_id_reg: the pipeline register with load/hold/clear controls and the NOP reset value. Decode reuses its output bundle.
- The PC register, next-PC mux, FSM and counter live in inst_fetch.

## Test plan
- Reset, start=1, ROM preloaded with 4 distinct words followed by 0x00000073 -> IF/ID shows PCs 0,4,8,12,16 on consecutive cycles; halted=1 after the 0x73 capture; fetch_count=5.
- stall held for 3 cycles at PC=8 -> rom_addr stays 8 and IF/ID keeps PC 4 for all 3 cycles; on release the sequence resumes at 8.
- redirect_valid with redirect_pc=0x20 while in RUN -> one bubble (if_id_valid=0), then if_id_pc=0x20; redirect together with stall gives the same result.
- redirect_pc=0x22 -> ERR, fetch_err=01, rom_read_enable=0, stays there until rst; a later redirect is ignored.
- Sequential fetch past word 15 (PC=0x40) with INST_MEM_SIZE=16 -> fetch_err=10 and no capture of PC 0x40.
- HALT entered, then redirect_pc=0x8 -> back in RUN with halted=0 and if_id_pc=0x8 two edges later; rst mid-run -> every output returns to its reset value.
